// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path:
// opcodes, controller state encoding, ALUOp / ALU_Control codes,
// datapath mux-select codes and the immediate-format helper.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_e;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_FN  = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, so it is valid in every state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU control decode for the multi-cycle controller (combinational).
// Ports:
//   alu_op      in  2  00 add, 01 sub, 10 decode from funct3/funct7
//   funct3      in  3  instr[14:12]
//   funct7      in  1  instr[30]
//   op5         in  1  op_code[5], distinguishes R-type (sub allowed) from I-type
//   alu_control out 3  operation code for the ALU
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FN: begin
                case (funct3)
                    // addi has no sub form; instr[30] is immediate data there
                    3'b000:  alu_control = (op5 && funct7) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM controller for a multi-cycle RV32I datapath with a single shared
// instruction/data memory. Sequences fetch/decode/execute/memory/writeback,
// waits on mem_ready for every memory access and flags unsupported opcodes.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   op_code/funct3/funct7 instruction fields from the IR
//   zero                 ALU zero flag (branch decision)
//   mem_ready            memory completed the current access this cycle
//   mem_req, Mem_write, IR_write, PC_write, Reg_write   datapath enables
//   Adr_Src, ImmSrc, ALU_SrcA, ALU_SrcB, Result_Src     datapath mux selects
//   ALU_Control          ALU operation
//   illegal_op           unsupported opcode reached decode
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op_code,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       Mem_write,
    output logic       IR_write,
    output logic       PC_write,
    output logic       Adr_Src,
    output logic       Reg_write,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALU_SrcA,
    output logic [1:0] ALU_SrcB,
    output logic [1:0] Result_Src,
    output logic [2:0] ALU_Control,
    output logic       illegal_op
);

    state_e     state_q, state_d;
    logic [1:0] alu_op;
    logic       mem_req_c, mem_write_c, ir_write_c, reg_write_c;
    logic       pc_update, branch;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        pc_update   = 1'b0;
        branch      = 1'b0;
        Adr_Src     = 1'b0;
        ALU_SrcA    = SRCA_PC;
        ALU_SrcB    = SRCB_RD2;
        Result_Src  = RES_ALUOUT;
        alu_op      = ALUOP_ADD;
        illegal_op  = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 computed by the ALU goes straight to PC (Result=ALUResult)
                mem_req_c  = 1'b1;
                ALU_SrcB   = SRCB_FOUR;
                Result_Src = RES_ALURES;
                ir_write_c = mem_ready;
                pc_update  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Speculative branch/jump target OldPC+imm lands in ALUOut
                ALU_SrcA = SRCA_OLDPC;
                ALU_SrcB = SRCB_IMM;
                case (op_code)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALU_SrcA = SRCA_RD1;
                ALU_SrcB = SRCB_IMM;
                state_d  = (op_code == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                Adr_Src   = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                Result_Src  = RES_RDATA;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c   = 1'b1;
                Adr_Src     = 1'b1;
                mem_write_c = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALU_SrcA = SRCA_RD1;
                ALU_SrcB = SRCB_RD2;
                alu_op   = ALUOP_FN;
                state_d  = S_ALUWB;
            end
            S_EXECI: begin
                ALU_SrcA = SRCA_RD1;
                ALU_SrcB = SRCB_IMM;
                alu_op   = ALUOP_FN;
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BEQ: begin
                ALU_SrcA = SRCA_RD1;
                ALU_SrcB = SRCB_RD2;
                alu_op   = ALUOP_SUB;
                branch   = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                // PC <- target held in ALUOut; OldPC+4 becomes ALUOut for rd next cycle
                ALU_SrcA  = SRCA_OLDPC;
                ALU_SrcB  = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal_op = 1'b1;
                state_d    = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // While rst is low the state is already FETCH, but mem_ready could still
    // raise FETCH's enables; masking with rst keeps every write off during reset.
    assign mem_req   = mem_req_c   & rst;
    assign Mem_write = mem_write_c & rst;
    assign IR_write  = ir_write_c  & rst;
    assign Reg_write = reg_write_c & rst;
    assign PC_write  = (pc_update | (branch & zero)) & rst;
    assign ImmSrc    = imm_src_of(op_code);

    alu_decoder u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7      (funct7),
        .op5         (op_code[5]),
        .alu_control (ALU_Control)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Two instances share all
// inputs: dut (HALT_ON_ILLEGAL=1) and dut0 (HALT_ON_ILLEGAL=0); they behave
// identically until an illegal opcode is decoded.
module tb_multicycle_controller;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111,
                           BAD = 7'b1111111;

    typedef enum int {T_FETCH, T_DECODE, T_ADDR, T_RD, T_LWB, T_WR,
                      T_EXR, T_EXI, T_WB, T_BR, T_JAL, T_ILL} step_e;

    logic       clk = 1'b0, rst = 1'b0;
    logic [6:0] op_code = RT;
    logic [2:0] funct3 = 3'b000;
    logic       funct7 = 1'b0, zero = 1'b0, mem_ready = 1'b0;

    logic       mem_req, Mem_write, IR_write, PC_write, Adr_Src, Reg_write, illegal_op;
    logic [1:0] ImmSrc, ALU_SrcA, ALU_SrcB, Result_Src;
    logic [2:0] ALU_Control;
    logic       h_mem_req, h_Mem_write, h_IR_write, h_PC_write, h_Adr_Src, h_Reg_write, h_illegal_op;
    logic [1:0] h_ImmSrc, h_ALU_SrcA, h_ALU_SrcB, h_Result_Src;
    logic [2:0] h_ALU_Control;

    int n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .op_code(op_code), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .Mem_write(Mem_write),
        .IR_write(IR_write), .PC_write(PC_write), .Adr_Src(Adr_Src), .Reg_write(Reg_write),
        .ImmSrc(ImmSrc), .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB), .Result_Src(Result_Src),
        .ALU_Control(ALU_Control), .illegal_op(illegal_op));

    multicycle_controller #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .op_code(op_code), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready), .mem_req(h_mem_req), .Mem_write(h_Mem_write),
        .IR_write(h_IR_write), .PC_write(h_PC_write), .Adr_Src(h_Adr_Src), .Reg_write(h_Reg_write),
        .ImmSrc(h_ImmSrc), .ALU_SrcA(h_ALU_SrcA), .ALU_SrcB(h_ALU_SrcB), .Result_Src(h_Result_Src),
        .ALU_Control(h_ALU_Control), .illegal_op(h_illegal_op));

    // {mem_req, Mem_write, IR_write, PC_write, Adr_Src, Reg_write,
    //  ImmSrc, ALU_SrcA, ALU_SrcB, Result_Src, ALU_Control, illegal_op}
    wire [17:0] obs  = {mem_req, Mem_write, IR_write, PC_write, Adr_Src, Reg_write,
                        ImmSrc, ALU_SrcA, ALU_SrcB, Result_Src, ALU_Control, illegal_op};
    wire [17:0] obs0 = {h_mem_req, h_Mem_write, h_IR_write, h_PC_write, h_Adr_Src, h_Reg_write,
                        h_ImmSrc, h_ALU_SrcA, h_ALU_SrcB, h_Result_Src, h_ALU_Control, h_illegal_op};

    task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [1:0] imm_ref(input logic [6:0] op);
        if (op == SW) return 2'b01;
        if (op == BQ) return 2'b10;
        if (op == JL) return 2'b11;
        return 2'b00;
    endfunction

    // ALU operation the instruction semantics call for
    function automatic logic [2:0] alu_ref(input int aluop, input logic [2:0] f3,
                                           input logic f7, input logic [6:0] op);
        if (aluop == 0) return 3'b000;
        if (aluop == 1) return 3'b001;
        if (f3 == 3'b000) return (op == RT && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    function automatic logic [17:0] exp_out(input step_e s, input logic mr, input logic z,
                                            input logic [6:0] op, input logic [2:0] f3,
                                            input logic f7);
        logic mq = 0, mw = 0, irw = 0, pcw = 0, adr = 0, rw = 0, ill = 0;
        logic [1:0] a = 0, b = 0, res = 0;
        int aluop = 0;
        case (s)
            T_FETCH:  begin mq = 1; b = 2; res = 2; irw = mr; pcw = mr; end
            T_DECODE: begin a = 1; b = 1; end
            T_ADDR:   begin a = 2; b = 1; end
            T_RD:     begin mq = 1; adr = 1; end
            T_LWB:    begin res = 1; rw = 1; end
            T_WR:     begin mq = 1; adr = 1; mw = 1; end
            T_EXR:    begin a = 2; aluop = 2; end
            T_EXI:    begin a = 2; b = 1; aluop = 2; end
            T_WB:     rw = 1;
            T_BR:     begin a = 2; aluop = 1; pcw = z; end
            T_JAL:    begin a = 1; b = 2; pcw = 1; end
            default:  ill = 1;
        endcase
        return {mq, mw, irw, pcw, adr, rw, imm_ref(op), a, b, res, alu_ref(aluop, f3, f7, op), ill};
    endfunction

    task automatic cyc2(input step_e s, input step_e s0, input logic mr, input string tag);
        @(negedge clk);
        mem_ready = mr;
        #1;
        chk(tag, obs, exp_out(s, mr, zero, op_code, funct3, funct7));
        chk({tag, "_h0"}, obs0, exp_out(s0, mr, zero, op_code, funct3, funct7));
    endtask

    task automatic cyc(input step_e s, input logic mr, input string tag);
        cyc2(s, s, mr, tag);
    endtask

    // kind: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal. fst/mst = stall cycles in fetch/memory.
    task automatic run_instr(input int kind, input int fst, input int mst,
                             input logic [2:0] f3, input logic f7, input logic z);
        logic [6:0] ops [6] = '{LW, SW, RT, IT, BQ, JL};
        op_code = ops[kind]; funct3 = f3; funct7 = f7; zero = z;
        for (int i = 0; i < fst; i++) cyc(T_FETCH, 1'b0, "fetch_wait");
        cyc(T_FETCH, 1'b1, "fetch");
        cyc(T_DECODE, 1'($urandom_range(0, 1)), "decode");
        case (kind)
            0: begin
                cyc(T_ADDR, 1'($urandom_range(0, 1)), "lw_adr");
                for (int i = 0; i < mst; i++) cyc(T_RD, 1'b0, "lw_wait");
                cyc(T_RD, 1'b1, "lw_rd");
                cyc(T_LWB, 1'($urandom_range(0, 1)), "lw_wb");
            end
            1: begin
                cyc(T_ADDR, 1'($urandom_range(0, 1)), "sw_adr");
                for (int i = 0; i < mst; i++) cyc(T_WR, 1'b0, "sw_wait");
                cyc(T_WR, 1'b1, "sw_wr");
            end
            2: begin
                cyc(T_EXR, 1'($urandom_range(0, 1)), "execr");
                cyc(T_WB, 1'($urandom_range(0, 1)), "r_wb");
            end
            3: begin
                cyc(T_EXI, 1'($urandom_range(0, 1)), "execi");
                cyc(T_WB, 1'($urandom_range(0, 1)), "i_wb");
            end
            4: cyc(T_BR, 1'($urandom_range(0, 1)), "beq");
            default: begin
                cyc(T_JAL, 1'($urandom_range(0, 1)), "jal");
                cyc(T_WB, 1'($urandom_range(0, 1)), "jal_wb");
            end
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_en", {13'b0, mem_req, Mem_write, IR_write, PC_write, Reg_write}, 18'd0);
        chk("rst_en_h0", {13'b0, h_mem_req, h_Mem_write, h_IR_write, h_PC_write, h_Reg_write}, 18'd0);
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        do_reset();
        cyc(T_FETCH, 1'b1, "post_rst_fetch");
        cyc(T_DECODE, 1'b1, "post_rst_decode");
        cyc(T_EXR, 1'b1, "post_rst_execr");
        cyc(T_WB, 1'b1, "post_rst_wb");

        // directed cases
        run_instr(2, 0, 0, 3'b000, 1'b0, 1'b0);   // add
        run_instr(2, 0, 0, 3'b000, 1'b1, 1'b0);   // sub
        run_instr(0, 0, 2, 3'b010, 1'b0, 1'b0);   // lw with 2 memory stalls
        run_instr(1, 1, 2, 3'b010, 1'b0, 1'b0);   // sw with stalls
        run_instr(4, 0, 0, 3'b000, 1'b0, 1'b1);   // beq taken
        run_instr(4, 0, 0, 3'b000, 1'b0, 1'b0);   // beq not taken
        run_instr(3, 0, 0, 3'b000, 1'b1, 1'b0);   // addi with instr[30]=1 stays add
        run_instr(5, 0, 0, 3'b000, 1'b0, 1'b0);   // jal

        // abort mid-EXECR
        op_code = RT; funct3 = 3'b111; funct7 = 1'b0;
        cyc(T_FETCH, 1'b1, "ab_fetch");
        cyc(T_DECODE, 1'b1, "ab_decode");
        cyc(T_EXR, 1'b1, "ab_execr");
        do_reset();
        cyc(T_FETCH, 1'b1, "ab_refetch");
        cyc(T_DECODE, 1'b0, "ab_decode2");
        cyc(T_EXR, 1'b0, "ab_execr2");
        cyc(T_WB, 1'b0, "ab_wb");

        // randomized instruction stream
        for (int i = 0; i < 60; i++)
            run_instr(int'($urandom_range(0, 5)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // illegal opcode: dut halts, dut0 pulses once and refetches
        op_code = BAD;
        cyc(T_FETCH, 1'b1, "ill_fetch");
        cyc(T_DECODE, 1'b1, "ill_decode");
        cyc(T_ILL, 1'b1, "ill_1");
        cyc2(T_ILL, T_FETCH, 1'b0, "ill_2");
        cyc2(T_ILL, T_FETCH, 1'b0, "ill_3");
        cyc2(T_ILL, T_FETCH, 1'b1, "ill_4");
        do_reset();
        op_code = RT;
        cyc(T_FETCH, 1'b0, "ill_rst_fetch");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
